// File: rtl/iobus_uart_tx.sv
// IOBUS-mapped UART transmitter: DATA writes queue bytes, STATUS reads report FIFO/FSM state; 8N1, or 8E1 with UART_TX_PARITY_EN.
// Latency: TX falls two clocks after an idle-block write. Backpressure: DATA writes to a full FIFO are dropped and set sticky OVF.

module iobus_uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

module iobus_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0100,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TX
);
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam int            FW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0]   STAT_ADDR = BASE_ADDR + 32'd4;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] bit_cnt, cnt_nxt;
  logic [2:0]    bit_idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;
  logic          bit_done;
  logic          pop;
  logic          push;
  logic          ovf;
  logic          wr_data;
  logic          wr_stat;
  logic [7:0]    fifo_rdata;
  logic [FW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          unused_out;
`ifdef UART_TX_PARITY_EN
  logic          parity;
`endif

  assign wr_data    = IOBUS_WR && (IOBUS_ADDR == BASE_ADDR);
  assign wr_stat    = IOBUS_WR && (IOBUS_ADDR == STAT_ADDR);
  // A full FIFO still accepts a write on the edge the FSM pops it.
  assign push       = wr_data && (!fifo_full || pop);
  assign bit_done   = (bit_cnt == BIT_LAST);
  assign unused_out = ^IOBUS_OUT[31:8];

  iobus_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (IOBUS_OUT[7:0]),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    idx_nxt   = bit_idx;
    shift_nxt = shift;
    pop       = 1'b0;
    tx_nxt    = 1'b1;
    if (state != IDLE) cnt_nxt = bit_done ? '0 : bit_cnt + CW'(1);
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_rdata;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = START;
        end
      end
      START: if (bit_done) state_nxt = DATA;
      DATA: begin
        if (bit_done) begin
          idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            shift_nxt = shift >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) state_nxt = STOP;
`endif
      STOP: if (bit_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // TX is registered from the next state so it changes on the same edge as the FSM.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nxt = parity;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      TX      <= 1'b1;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
      bit_idx <= idx_nxt;
      shift   <= shift_nxt;
      TX      <= tx_nxt;
      if (wr_data && !push)            ovf <= 1'b1;
      else if (wr_stat && IOBUS_OUT[3]) ovf <= 1'b0;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RST)      parity <= 1'b0;
    else if (pop) parity <= ^fifo_rdata;
  end
`endif

  always_comb begin
    IOBUS_IN = '0;
    if (IOBUS_ADDR == STAT_ADDR) begin
      IOBUS_IN[12:8] = 5'(fifo_count);
      IOBUS_IN[3]    = ovf;
      IOBUS_IN[2]    = fifo_empty;
      IOBUS_IN[1]    = fifo_full;
      IOBUS_IN[0]    = (state != IDLE);
    end
  end
endmodule

// File: tb/tb_iobus_uart_tx.sv
// Bench for iobus_uart_tx: frame-level reference model checked every cycle, plus directed literal checks.
module tb_iobus_uart_tx;
  localparam int          C    = 4;
  localparam int          D    = 4;
  localparam logic [31:0] BASE = 32'h1100_0100;
  localparam logic [31:0] STAT = BASE + 32'd4;
`ifdef UART_TX_PARITY_EN
  localparam int          NB   = 11;
`else
  localparam int          NB   = 10;
`endif
  localparam int          LEN  = NB * C;
  localparam int          B2B  = (NB == 11) ? 89 : 81;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT = '0;
  logic [31:0] IOBUS_IN;
  logic        TX;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model: pending byte queue, position within the current frame (-1 = line idle).
  logic [7:0] m_q[$];
  int         m_pos = -1;
  logic [7:0] m_cur = '0;
  bit         m_ovf = 1'b0;

  iobus_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .TX         (TX)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_tx();
    int k;
    if (m_pos < 0) return 1'b1;
    k = m_pos / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    if (NB == 11 && k == 9) return ^m_cur;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_status(input logic [31:0] a);
    logic [31:0] s;
    s = '0;
    if (a == STAT) begin
      s[12:8] = 5'(m_q.size());
      s[3]    = m_ovf;
      s[2]    = (m_q.size() == 0);
      s[1]    = (m_q.size() == D);
      s[0]    = (m_pos >= 0);
    end
    return s;
  endfunction

  task automatic m_update(input logic rst, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bit pop_now, accept, set_ovf;
    if (rst) begin
      m_q.delete();
      m_pos = -1;
      m_ovf = 1'b0;
      return;
    end
    pop_now = (m_pos < 0) && (m_q.size() > 0);
    accept  = 1'b0;
    set_ovf = 1'b0;
    if (wr && a == BASE) begin
      if (m_q.size() < D || pop_now) accept = 1'b1;
      else set_ovf = 1'b1;
    end
    if (pop_now) begin
      m_cur = m_q.pop_front();
      m_pos = 0;
    end else if (m_pos >= 0) begin
      m_pos = (m_pos == LEN - 1) ? -1 : m_pos + 1;
    end
    if (accept) m_q.push_back(d[7:0]);
    if (set_ovf) m_ovf = 1'b1;
    else if (wr && a == STAT && d[3]) m_ovf = 1'b0;
  endtask

  task automatic cycle(input logic rst, input logic wr, input logic [31:0] a, input logic [31:0] d);
    RST        = rst;
    IOBUS_WR   = wr;
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    @(posedge CLK);
    m_update(rst, wr, a, d);
    #1;
  endtask

  task automatic idle(input int n, input logic [31:0] a);
    repeat (n) cycle(1'b0, 1'b0, a, 32'h0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400; i++) begin
      if (m_pos < 0 && m_q.size() == 0) break;
      idle(1, STAT);
    end
    check(name, {31'b0, (m_pos < 0 && m_q.size() == 0)}, 32'd1);
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("tx_model", {31'b0, TX}, {31'b0, m_tx()});
      check("iobus_in_model", IOBUS_IN, m_status(IOBUS_ADDR));
    end
  end

  initial begin
    logic [10:0] pat;
    int          n;
    int          r;
    logic [31:0] a;

    // Reset
    cycle(1'b1, 1'b0, STAT, 32'h0);
    cycle(1'b1, 1'b0, STAT, 32'h0);
    chk_en = 1'b1;
    idle(1, STAT);
    check("reset_status", IOBUS_IN, 32'h0000_0004);
    check("reset_tx", {31'b0, TX}, 32'd1);
    IOBUS_ADDR = BASE;
    #1;
    check("data_read_zero", IOBUS_IN, 32'h0);

    // Single byte 0xA5
`ifdef UART_TX_PARITY_EN
    pat = 11'b101_0100_1010;
`else
    pat = 11'b011_0100_1010;
`endif
    cycle(1'b0, 1'b1, BASE, 32'hDEAD_BEA5);
    idle(1, STAT);
    check("a5_busy_status", IOBUS_IN, 32'h0000_0005);
    for (int b = 0; b < NB; b++) begin
      check("a5_bit", {31'b0, TX}, {31'b0, pat[b]});
      idle(C, STAT);
    end
    check("a5_done_status", IOBUS_IN, 32'h0000_0004);

    // Overflow: six back-to-back writes while idle
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, BASE, 32'h10 + i);
    IOBUS_WR = 1'b0;
    IOBUS_ADDR = STAT;
    #1;
    check("ovf_status", IOBUS_IN, 32'h0000_040B);
    cycle(1'b0, 1'b1, STAT, 32'h8);
    IOBUS_WR = 1'b0;
    #1;
    check("ovf_clear_status", IOBUS_IN, 32'h0000_0403);

    // Push on the same edge as a pop from a full FIFO
    for (int i = 0; i < 60; i++) begin
      if (m_pos < 0) break;
      idle(1, STAT);
    end
    check("pop_edge_ready", {31'b0, (m_pos < 0 && m_q.size() == D)}, 32'd1);
    cycle(1'b0, 1'b1, BASE, 32'h77);
    IOBUS_WR = 1'b0;
    IOBUS_ADDR = STAT;
    #1;
    check("push_on_pop_status", IOBUS_IN, 32'h0000_0403);
    drain("drain_after_pop");

    // Back-to-back 0x00 then 0xFF
    cycle(1'b0, 1'b1, BASE, 32'h00);
    cycle(1'b0, 1'b1, BASE, 32'hFF);
    check("b2b_start_low", {31'b0, TX}, 32'd0);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      idle(1, STAT);
      n++;
      if (IOBUS_IN[2:0] == 3'b100) break;
    end
    check("b2b_cycles", n, B2B);

    // Reset during data bit 3 with bytes still queued
    cycle(1'b0, 1'b1, BASE, 32'h3C);
    cycle(1'b0, 1'b1, BASE, 32'h5A);
    cycle(1'b0, 1'b1, BASE, 32'h99);
    for (int i = 0; i < 40; i++) begin
      if (m_pos >= 0 && m_pos / C == 4) break;
      idle(1, STAT);
    end
    check("midframe_reached", {31'b0, (m_pos >= 0 && m_pos / C == 4)}, 32'd1);
    cycle(1'b1, 1'b0, STAT, 32'h0);
    check("rst_mid_tx", {31'b0, TX}, 32'd1);
    check("rst_mid_status", IOBUS_IN, 32'h0000_0004);
    for (int i = 0; i < 60; i++) begin
      idle(1, STAT);
      check("post_rst_tx_high", {31'b0, TX}, 32'd1);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      case ($urandom_range(0, 3))
        0:       a = BASE;
        1:       a = STAT;
        2:       a = BASE + 32'd8;
        default: a = $urandom;
      endcase
      if (r < 45)      cycle(1'b0, 1'b1, BASE, $urandom);
      else if (r < 60) cycle(1'b0, 1'b1, STAT, $urandom);
      else if (r < 70) cycle(1'b0, 1'b1, a, $urandom);
      else if (r < 73) cycle(1'b1, 1'b0, a, $urandom);
      else             cycle(1'b0, 1'b0, a, $urandom);
    end
    drain("drain_final");
    idle(1, STAT);
    check("final_status", IOBUS_IN, {28'h0, m_ovf, 3'b100});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
